// File: rtl/branch_rs_if.sv
// Dispatch, result-broadcast and issue bundle of the branch reservation station.
// slave: the reservation station itself; master: dispatcher / CDB / branch-unit side.
interface branch_rs_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 4,
  parameter int unsigned OP_W   = 6
);
  logic              disp_en_i;
  logic [OP_W-1:0]   disp_op_i;
  logic [DATA_W-1:0] disp_vj_i;
  logic [TAG_W-1:0]  disp_qj_i;
  logic [DATA_W-1:0] disp_vk_i;
  logic [TAG_W-1:0]  disp_qk_i;
  logic [DATA_W-1:0] disp_imm_i;
  logic [DATA_W-1:0] disp_pc_i;
  logic [TAG_W-1:0]  disp_des_i;
  logic              disp_bp_i;
  logic              cdb0_en_i;
  logic [TAG_W-1:0]  cdb0_tag_i;
  logic [DATA_W-1:0] cdb0_data_i;
  logic              cdb1_en_i;
  logic [TAG_W-1:0]  cdb1_tag_i;
  logic [DATA_W-1:0] cdb1_data_i;
  logic              full_o;
  logic              branch_en_o;
  logic [OP_W-1:0]   op_o;
  logic [DATA_W-1:0] reg1_o;
  logic [DATA_W-1:0] reg2_o;
  logic [TAG_W-1:0]  des_o;
  logic [DATA_W-1:0] imm_o;
  logic [DATA_W-1:0] pc_o;
  logic              bp_o;

  modport slave (
    input  disp_en_i, disp_op_i, disp_vj_i, disp_qj_i, disp_vk_i, disp_qk_i,
           disp_imm_i, disp_pc_i, disp_des_i, disp_bp_i,
           cdb0_en_i, cdb0_tag_i, cdb0_data_i, cdb1_en_i, cdb1_tag_i, cdb1_data_i,
    output full_o, branch_en_o, op_o, reg1_o, reg2_o, des_o, imm_o, pc_o, bp_o
  );

  modport master (
    output disp_en_i, disp_op_i, disp_vj_i, disp_qj_i, disp_vk_i, disp_qk_i,
           disp_imm_i, disp_pc_i, disp_des_i, disp_bp_i,
           cdb0_en_i, cdb0_tag_i, cdb0_data_i, cdb1_en_i, cdb1_tag_i, cdb1_data_i,
    input  full_o, branch_en_o, op_o, reg1_o, reg2_o, des_o, imm_o, pc_o, bp_o
  );
endinterface

// File: rtl/branch_rs.sv
// Reservation station for control-flow instructions feeding the branch unit.
// Optional macro BRS_OLDEST_FIRST_EN: issue picks the oldest ready entry instead of lowest index.
module branch_rs #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 4,
  parameter int unsigned OP_W   = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rdy_i,
  input  logic       clear_i,
  branch_rs_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(DEPTH);

  typedef struct packed {
    logic [TAG_W-1:0]  q;
    logic [DATA_W-1:0] v;
  } opnd_t;

  typedef struct packed {
    logic              en;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } cdb_t;

  typedef struct packed {
    logic              valid;
    logic [OP_W-1:0]   op;
    opnd_t             j;
    opnd_t             k;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc;
    logic [TAG_W-1:0]  des;
    logic              bp;
  } ent_t;

  // Capture a broadcast value for a pending operand; cdb0 has priority, tag 0 never matches.
  function automatic opnd_t f_snoop(input opnd_t o, input cdb_t c0, input cdb_t c1);
    opnd_t res;
    res = o;
    if (o.q != '0) begin
      if (c0.en && (c0.tag == o.q)) begin
        res.q = '0;
        res.v = c0.data;
      end else if (c1.en && (c1.tag == o.q)) begin
        res.q = '0;
        res.v = c1.data;
      end
    end
    return res;
  endfunction

  ent_t              r_ent [DEPTH];
  ent_t              w_nxt [DEPTH];
  ent_t              w_new;
  cdb_t              w_cdb0;
  cdb_t              w_cdb1;
  logic              w_sel_found;
  logic [IDX_W-1:0]  w_sel_idx;
  logic              w_free_found;
  logic [IDX_W-1:0]  w_free_idx;
  logic              w_disp;

  logic              r_branch_en;
  logic [OP_W-1:0]   r_op;
  logic [DATA_W-1:0] r_reg1;
  logic [DATA_W-1:0] r_reg2;
  logic [TAG_W-1:0]  r_des;
  logic [DATA_W-1:0] r_imm;
  logic [DATA_W-1:0] r_pc;
  logic              r_bp;

  assign w_cdb0 = {bus.cdb0_en_i, bus.cdb0_tag_i, bus.cdb0_data_i};
  assign w_cdb1 = {bus.cdb1_en_i, bus.cdb1_tag_i, bus.cdb1_data_i};

`ifdef BRS_OLDEST_FIRST_EN
  localparam int unsigned CNT_W = IDX_W + 1;
  logic [IDX_W-1:0] r_rank     [DEPTH];
  logic [IDX_W-1:0] w_nxt_rank [DEPTH];
  logic [CNT_W-1:0] w_vcnt;
`endif

  // Issue selection from registered entry state.
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_ent[i].valid && (r_ent[i].j.q == '0) && (r_ent[i].k.q == '0)) begin
`ifdef BRS_OLDEST_FIRST_EN
        if (!w_sel_found || (r_rank[i] < r_rank[w_sel_idx])) begin
`else
        if (!w_sel_found) begin
`endif
          w_sel_found = 1'b1;
          w_sel_idx   = IDX_W'(i);
        end
      end
    end
  end

  always_comb begin
    w_free_found = 1'b0;
    w_free_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!r_ent[i].valid && !w_free_found) begin
        w_free_found = 1'b1;
        w_free_idx   = IDX_W'(i);
      end
    end
  end

  assign bus.full_o = ~w_free_found;
  assign w_disp     = bus.disp_en_i & w_free_found;

  always_comb begin
    w_new       = '0;
    w_new.valid = 1'b1;
    w_new.op    = bus.disp_op_i;
    w_new.j     = f_snoop({bus.disp_qj_i, bus.disp_vj_i}, w_cdb0, w_cdb1);
    w_new.k     = f_snoop({bus.disp_qk_i, bus.disp_vk_i}, w_cdb0, w_cdb1);
    w_new.imm   = bus.disp_imm_i;
    w_new.pc    = bus.disp_pc_i;
    w_new.des   = bus.disp_des_i;
    w_new.bp    = bus.disp_bp_i;
  end

  // Next entry state: wake-up, then issue invalidation, then dispatch into the free slot.
  always_comb begin
    w_nxt = r_ent;
    for (int i = 0; i < DEPTH; i++) begin
      w_nxt[i].j = f_snoop(r_ent[i].j, w_cdb0, w_cdb1);
      w_nxt[i].k = f_snoop(r_ent[i].k, w_cdb0, w_cdb1);
    end
    if (w_sel_found) w_nxt[w_sel_idx].valid = 1'b0;
    if (w_disp)      w_nxt[w_free_idx]       = w_new;
  end

`ifdef BRS_OLDEST_FIRST_EN
  // Ranks stay a dense 0..n-1 ordering of the valid entries.
  always_comb begin
    w_vcnt = '0;
    for (int i = 0; i < DEPTH; i++) w_vcnt = w_vcnt + CNT_W'(r_ent[i].valid);
    w_nxt_rank = r_rank;
    if (w_sel_found) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r_rank[i] > r_rank[w_sel_idx]) w_nxt_rank[i] = r_rank[i] - 1'b1;
      end
    end
    if (w_disp) w_nxt_rank[w_free_idx] = IDX_W'(w_vcnt - CNT_W'(w_sel_found));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_rank[i] <= '0;
    end else if (rdy_i) begin
      if (clear_i) begin
        for (int i = 0; i < DEPTH; i++) r_rank[i] <= '0;
      end else begin
        r_rank <= w_nxt_rank;
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
      r_branch_en <= 1'b0;
      r_op        <= '0;
      r_reg1      <= '0;
      r_reg2      <= '0;
      r_des       <= '0;
      r_imm       <= '0;
      r_pc        <= '0;
      r_bp        <= 1'b0;
    end else if (rdy_i) begin
      if (clear_i) begin
        for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
        r_branch_en <= 1'b0;
      end else begin
        r_ent       <= w_nxt;
        r_branch_en <= w_sel_found;
        if (w_sel_found) begin
          r_op   <= r_ent[w_sel_idx].op;
          r_reg1 <= r_ent[w_sel_idx].j.v;
          r_reg2 <= r_ent[w_sel_idx].k.v;
          r_des  <= r_ent[w_sel_idx].des;
          r_imm  <= r_ent[w_sel_idx].imm;
          r_pc   <= r_ent[w_sel_idx].pc;
          r_bp   <= r_ent[w_sel_idx].bp;
        end
      end
    end
  end

  assign bus.branch_en_o = r_branch_en;
  assign bus.op_o        = r_op;
  assign bus.reg1_o      = r_reg1;
  assign bus.reg2_o      = r_reg2;
  assign bus.des_o       = r_des;
  assign bus.imm_o       = r_imm;
  assign bus.pc_o        = r_pc;
  assign bus.bp_o        = r_bp;
endmodule

// File: doc/branch_rs.md
Name: branch_rs

Overview:
Reservation station for control-flow instructions (JAL, JALR, BEQ, BNE, BLT, BGE, BLTU, BGEU), directly upstream of the combinational branch execution unit.
- Accepts one dispatched instruction per cycle from the decoder/dispatcher.
- Holds each entry until both source operands are resolved, snooping two result broadcast buses.
- Issues at most one ready entry per cycle on a registered issue port, consumed by the branch unit.
- A misprediction clear flushes every entry.

Parameters:
DEPTH, 8, number of entries (power of two, 2..16)
DATA_W, 32, operand/immediate/pc width
TAG_W, 4, ROB tag width; tag value 0 means "operand ready, no producer"
OP_W, 6, internal opcode width

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
rdy_i  in  1  global ready; when 0 all state and outputs hold
clear_i  in  1  misprediction flush
disp_en_i  in  1  dispatch valid
disp_op_i  in  OP_W  opcode
disp_vj_i  in  DATA_W  rs1 value (valid when disp_qj_i==0)
disp_qj_i  in  TAG_W  rs1 producer tag
disp_vk_i  in  DATA_W  rs2 value
disp_qk_i  in  TAG_W  rs2 producer tag
disp_imm_i  in  DATA_W  sign-extended immediate
disp_pc_i  in  DATA_W  instruction pc
disp_des_i  in  TAG_W  destination ROB tag
disp_bp_i  in  1  predictor outcome carried through
cdb0_en_i  in  1  ALU broadcast valid
cdb0_tag_i  in  TAG_W  ALU broadcast tag
cdb0_data_i  in  DATA_W  ALU broadcast value
cdb1_en_i  in  1  load broadcast valid
cdb1_tag_i  in  TAG_W  load broadcast tag
cdb1_data_i  in  DATA_W  load broadcast value
full_o  out  1  no free entry
branch_en_o  out  1  issue valid to branch unit
op_o  out  OP_W  issued opcode
reg1_o  out  DATA_W  issued rs1 value
reg2_o  out  DATA_W  issued rs2 value
des_o  out  TAG_W  issued ROB tag
imm_o  out  DATA_W  issued immediate
pc_o  out  DATA_W  issued pc
bp_o  out  1  issued prediction bit

Behaviour:
- Reset (rst_n==0 at a clk edge): all entries invalid; branch_en_o=0; op_o, reg1_o, reg2_o, des_o, imm_o, pc_o, bp_o = 0; full_o=0.
- rdy_i==0: no state change of any kind; outputs hold their last values. Reset overrides rdy_i.
- clear_i==1 (with rdy_i==1): all entries invalid and branch_en_o=0 at the next edge; dispatch and issue in the same cycle are discarded. Reset dominates clear.
- full_o: combinational; 1 when all DEPTH entries are valid. A dispatch while full_o==1 is ignored; the dispatcher must not assert it. An issue in the same cycle does not lower full_o early.
- Dispatch:
  - Written at the edge into the lowest-index free entry.
  - Operand capture: if the operand tag is nonzero and matches a valid CDB tag in the same cycle, the CDB value is captured and the tag is stored as 0; otherwise the dispatch value/tag is stored as given.
  - If both buses match the same tag, cdb0 wins.
- Wake-up: every valid entry with qj/qk equal to a valid cdb tag (nonzero) captures the data and clears its tag at the edge. Tag 0 never matches.
- Ready: valid && qj==0 && qk==0, computed from registered entry state. An entry woken or dispatched at edge k is first eligible in the cycle after edge k.
- Issue:
  - Each cycle, select one ready entry (lowest index by default).
  - At the edge, register its fields to the issue outputs, set branch_en_o=1 and invalidate the entry.
  - With no ready entry, branch_en_o=0 at the edge; data outputs are don't-care but hold their old values.
  - branch_en_o is a one-cycle pulse per issued instruction. The branch unit never stalls.
- Latency: dispatch with both operands ready at edge k → branch_en_o high after edge k+1.
- Simultaneous dispatch and issue are both performed; the freed slot may be reused in the following cycle.
- JAL entries: dispatched with qj=qk=0; their values are don't-care and pass through.

Optional Feature:
BRS_OLDEST_FIRST_EN
- Defined: each entry keeps an age rank of width clog2(DEPTH).
  - On dispatch, rank = number of currently valid entries that are not issuing this cycle.
  - On issue, every entry with rank greater than the issued rank decrements.
  - On clear/reset, all ranks are 0.
  - Selection picks the ready entry with the smallest rank (program order).
- Undefined: no rank storage; selection is lowest index.

Test Plan:
1. Reset, then dispatch BEQ with pc=0x100, vj=vk=5, qj=qk=0, imm=0x20, des=3, bp=1 → branch_en_o high exactly two edges after dispatch, with reg1_o=reg2_o=5, pc_o=0x100, imm_o=0x20, des_o=3, bp_o=1; entry then freed.
2. Dispatch BNE with qj=7; 3 cycles later cdb1 en, tag=7, data=0xDEAD → issue on the edge after wake-up with reg1_o=0xDEAD; no issue before.
3. Dispatch with qk=2 while cdb0 broadcasts tag=2, data=9 in the same cycle → captured; issued next cycle with reg2_o=9. Same-tag broadcast on both buses → cdb0 value taken.
4. Dispatch 8 entries, all with qj=5 → full_o=1; a 9th dispatch is ignored. Broadcast tag=5 → 8 consecutive branch_en_o pulses, then full_o=0.
5. With 4 waiting entries, assert clear_i together with a dispatch → next cycle all entries invalid, branch_en_o=0, full_o=0, and a later broadcast causes no issue.
6. Hold rdy_i=0 for 3 cycles during a CDB broadcast and a dispatch → no capture, outputs frozen; with BRS_OLDEST_FIRST_EN, two entries readied in the same cycle issue in dispatch order regardless of index.
